// File: rtl/input_sequencer.sv
// input_sequencer: accepts one displacement triple, holds it on the datapath,
// steps the selector through codes 1..N_STEPS and presents each registered
// result set downstream under its own valid/ready handshake.
module input_sequencer #(
    parameter int pd      = 12,
    parameter int p       = 22,
    parameter int N_STEPS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [pd+p-1:0]   d0_in,
    input  logic [pd+p-1:0]   d1_in,
    input  logic [pd+p-1:0]   d2_in,
    input  logic              abort,
    output logic [pd+p-1:0]   d0,
    output logic [pd+p-1:0]   d1,
    output logic [pd+p-1:0]   d2,
    output logic [2:0]        cntr,
    input  logic [8+p-1:0]    p0_dp,
    input  logic [8+p-1:0]    p1_dp,
    input  logic [8+p-1:0]    p2_dp,
    input  logic [8+p-1:0]    p3_dp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8+p-1:0]    out_p0,
    output logic [8+p-1:0]    out_p1,
    output logic [8+p-1:0]    out_p2,
    output logic [8+p-1:0]    out_p3,
    output logic [2:0]        out_step,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    // Handshake strobes; abort suppresses every one of them.
    logic accept;
    logic capture;
    logic consume;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = STEP;
                end
            end
            STEP: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    consume    = 1'b1;
                    state_next = out_last ? IDLE : STEP;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            accept     = 1'b0;
            capture    = 1'b0;
            consume    = 1'b0;
            state_next = IDLE;
        end
    end

    // Triple held on the datapath; changes only on an accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else if (accept) begin
            d0 <= d0_in;
            d1 <= d1_in;
            d2 <= d2_in;
        end
    end

    // Selector: starts at 1 on accept, advances on each consumed non-last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr <= 3'd0;
        end else if (abort) begin
            cntr <= 3'd0;
        end else if (accept) begin
            cntr <= 3'd1;
        end else if (consume) begin
            cntr <= out_last ? 3'd0 : cntr + 3'd1;
        end
    end

    // Output handshake and step tags; abort clears valid and tags but keeps data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_step  <= 3'd0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_step  <= 3'd0;
            out_last  <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_step  <= cntr;
            out_last  <= (cntr == 3'(N_STEPS));
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Result registers sample the settled datapath at the end of STEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p0 <= '0;
            out_p1 <= '0;
            out_p2 <= '0;
            out_p3 <= '0;
        end else if (capture) begin
            out_p0 <= p0_dp;
            out_p1 <= p1_dp;
            out_p2 <= p2_dp;
            out_p3 <= p3_dp;
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_input_sequencer.sv
// Testbench for input_sequencer: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the sequencing rules.
module tb_input_sequencer;

    localparam int PD = 12;
    localparam int P  = 22;
    localparam int NS = 6;
    localparam int DW = PD + P;
    localparam int RW = 8 + P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] d0_in, d1_in, d2_in;
    logic          abort;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    cntr;
    logic [RW-1:0] p0_dp, p1_dp, p2_dp, p3_dp;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_p0, out_p1, out_p2, out_p3;
    logic [2:0]    out_step;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    input_sequencer #(.pd(PD), .p(P), .N_STEPS(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .d0_in(d0_in), .d1_in(d1_in), .d2_in(d2_in),
        .abort(abort),
        .d0(d0), .d1(d1), .d2(d2), .cntr(cntr),
        .p0_dp(p0_dp), .p1_dp(p1_dp), .p2_dp(p2_dp), .p3_dp(p3_dp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
        .out_step(out_step), .out_last(out_last), .busy(busy)
    );

    // Stand-in for the external combinational datapath.
    function automatic logic [RW-1:0] dpf(input int k, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] c,
                                          input logic [2:0] s);
        logic [DW-1:0] t;
        t = (a ^ (b << (k + 1))) + (c >> k) + ({31'b0, s} * 34'h12345) + DW'(k);
        return t[RW-1:0];
    endfunction

    assign p0_dp = dpf(0, d0, d1, d2, cntr);
    assign p1_dp = dpf(1, d0, d1, d2, cntr);
    assign p2_dp = dpf(2, d0, d1, d2, cntr);
    assign p3_dp = dpf(3, d0, d1, d2, cntr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: current triple, step being worked on, edges
    // remaining before that step's result is presented.
    logic          m_busy = 1'b0;
    int            m_step = 0;
    int            m_wait = 0;
    logic [DW-1:0] m_d0 = '0, m_d1 = '0, m_d2 = '0;
    int            tick_no = 0;
    int            accept_edge = 0;
    int            consume_edge = 0;
    int            consumed = 0;
    logic          acc_flag;

    // One clock: observe and check at the falling edge, then drive inputs for
    // the coming rising edge and advance the model across it.
    task automatic tick(input logic iv, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic ordy, input logic ab);
        logic exp_valid;
        @(negedge clk);
        tick_no++;
        acc_flag  = 1'b0;
        exp_valid = m_busy && (m_wait == 0);
        chk("in_ready", in_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, exp_valid);
        chk("cntr", cntr, m_busy ? m_step : 0);
        chk("d0", d0, m_d0);
        chk("d1", d1, m_d1);
        chk("d2", d2, m_d2);
        if (exp_valid) begin
            chk("out_p0", out_p0, dpf(0, m_d0, m_d1, m_d2, 3'(m_step)));
            chk("out_p1", out_p1, dpf(1, m_d0, m_d1, m_d2, 3'(m_step)));
            chk("out_p2", out_p2, dpf(2, m_d0, m_d1, m_d2, 3'(m_step)));
            chk("out_p3", out_p3, dpf(3, m_d0, m_d1, m_d2, 3'(m_step)));
            chk("out_step", out_step, m_step);
            chk("out_last", out_last, m_step == NS);
        end
        in_valid  = iv;
        d0_in     = a;
        d1_in     = b;
        d2_in     = c;
        out_ready = ordy;
        abort     = ab;
        if (ab) begin
            m_busy = 1'b0;
            m_step = 0;
        end else if (!m_busy) begin
            if (iv) begin
                m_busy = 1'b1;
                m_step = 1;
                m_wait = 1;
                m_d0 = a; m_d1 = b; m_d2 = c;
                accept_edge = tick_no;
                acc_flag = 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (ordy) begin
            $display("tx step=%0d last=%0b p0=%h p1=%h p2=%h p3=%h",
                     out_step, out_last, out_p0, out_p1, out_p2, out_p3);
            consumed++;
            consume_edge = tick_no;
            if (m_step == NS) begin
                m_busy = 1'b0;
                m_step = 0;
            end else begin
                m_step++;
                m_wait = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    // Run with out_ready high until the model is about to present step s.
    task automatic run_to_step(input int s);
        for (int i = 0; i < 40 && !(m_busy && m_step == s && m_wait == 0); i++)
            tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    localparam logic [DW-1:0] ONE = 34'h0_0040_0000;

    initial begin
        int first_valid, ret, c0, pend_ok;
        logic [DW-1:0] ta, tb, tc;
        logic pend;

        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        d0_in = '0; d1_in = '0; d2_in = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cntr", cntr, 0);
        chk("rst_out_p0", out_p0, 0);
        chk("rst_out_p3", out_p3, 0);
        chk("rst_out_step", out_step, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_d1", d1, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Basic sequence with latency measurement.
        tick(1'b1, '0, ONE, '0, 1'b1, 1'b0);
        c0 = accept_edge; first_valid = -1; ret = -1;
        for (int i = 0; i < 20 && ret < 0; i++) begin
            tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
            if (first_valid < 0 && out_valid) first_valid = tick_no - 1 - c0;
            if (in_ready) ret = tick_no - 1 - c0;
        end
        chk("first_valid_lat", first_valid, 1);
        chk("ready_return_lat", ret, 2 * NS);

        // Backpressure at step 2.
        tick(1'b1, rnd(), rnd(), rnd(), 1'b1, 1'b0);
        run_to_step(2);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drain();

        // New triple offered while busy is held off, accepted right after the last result.
        tick(1'b1, rnd(), rnd(), rnd(), 1'b1, 1'b0);
        ta = rnd(); tb = rnd(); tc = rnd();
        pend_ok = 0;
        for (int i = 0; i < 40 && !pend_ok; i++) begin
            tick(1'b1, ta, tb, tc, 1'b1, 1'b0);
            if (acc_flag) pend_ok = 1;
        end
        chk("holdoff_accept_gap", accept_edge - consume_edge, 1);
        drain();

        // Abort together with out_ready at step 4.
        tick(1'b1, ta, tb, tc, 1'b1, 1'b0);
        run_to_step(4);
        c0 = consumed;
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1);
        tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("abort_out_step", out_step, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_kept_p0", out_p0, dpf(0, ta, tb, tc, 3'd4));
        chk("abort_not_consumed", consumed - c0, 0);
        idle(2);

        // Asynchronous reset mid-hold at step 3.
        tick(1'b1, rnd(), rnd(), rnd(), 1'b1, 1'b0);
        run_to_step(3);
        tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cntr", cntr, 0);
        chk("mid_rst_d0", d0, 0);
        chk("mid_rst_out_p1", out_p1, 0);
        chk("mid_rst_out_step", out_step, 0);
        m_busy = 1'b0; m_step = 0; m_d0 = '0; m_d1 = '0; m_d2 = '0;
        #1 rst_n = 1'b1;
        idle(4);

        // Back-to-back triples.
        c0 = consumed;
        tick(1'b1, rnd(), rnd(), rnd(), 1'b1, 1'b0);
        ta = rnd(); tb = rnd(); tc = rnd();
        pend_ok = 0;
        for (int i = 0; i < 40 && !pend_ok; i++) begin
            tick(1'b1, ta, tb, tc, 1'b1, 1'b0);
            if (acc_flag) pend_ok = 1;
        end
        drain();
        chk("b2b_results", consumed - c0, 2 * NS);

        // Randomized traffic with backpressure and occasional aborts.
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 9) < 4) begin
                pend = 1'b1; ta = rnd(); tb = rnd(); tc = rnd();
            end
            tick(pend, ta, tb, tc, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            if (acc_flag) pend = 1'b0;
        end
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
